// File: rtl/mem_resp_stage_pkg.sv
// rtl/mem_resp_stage_pkg.sv - shared types and constants for the MEM response stage
package mem_resp_stage_pkg;

    typedef enum logic [1:0] {
        MS_EMPTY = 2'd0,
        MS_WAIT  = 2'd1,
        MS_READY = 2'd2,
        MS_DRAIN = 2'd3
    } ms_state_e;

    // load_op is one-hot {d,wu,hu,bu,w,h,b}
    localparam int LD_B    = 0;
    localparam int LD_H    = 1;
    localparam int LD_W    = 2;
    localparam int LD_BU   = 3;
    localparam int LD_HU   = 4;
    localparam int LD_WU   = 5;
    localparam int LD_D    = 6;
    localparam int LD_OP_W = 7;

    function automatic int off_w(input int xlen);
        return (xlen == 64) ? 3 : 2;
    endfunction

endpackage

// File: rtl/mem_resp_stage_load_align.sv
// rtl/mem_resp_stage_load_align.sv - combinational load lane select, extend and misalignment flag
module load_align
    import mem_resp_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = off_w(XLEN)
) (
    input  logic [XLEN-1:0]    rdata,
    input  logic [OFF_W-1:0]   offset,
    input  logic [LD_OP_W-1:0] load_op,
    output logic [XLEN-1:0]    result,
    output logic               ale
);

    logic [OFF_W+2:0] shamt;
    logic [XLEN-1:0]  shifted;

    always_comb begin
        shamt   = {offset, 3'b000};
        shifted = rdata >> shamt;
        ale     = ((load_op[LD_H] | load_op[LD_HU]) & offset[0])
                | ((load_op[LD_W] | load_op[LD_WU]) & (offset[1:0] != 2'b00))
                | (load_op[LD_D] & (offset != '0));
        result  = '0;
        // A misaligned access never drives data; wu/d only exist on 64-bit datapaths.
        if (!ale) begin
            if (load_op[LD_B])                       result = XLEN'($signed(shifted[7:0]));
            else if (load_op[LD_H])                  result = XLEN'($signed(shifted[15:0]));
            else if (load_op[LD_W])                  result = XLEN'($signed(shifted[31:0]));
            else if (load_op[LD_BU])                 result = XLEN'(shifted[7:0]);
            else if (load_op[LD_HU])                 result = XLEN'(shifted[15:0]);
            else if (load_op[LD_WU] && XLEN == 64)   result = XLEN'(shifted[31:0]);
            else if (load_op[LD_D] && XLEN == 64)    result = shifted;
        end
    end

endmodule

// File: rtl/mem_resp_stage.sv
// rtl/mem_resp_stage.sv - MEM pipeline stage holding one instruction and its data-SRAM response
module mem_resp_stage
    import mem_resp_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               ws_allowin,
    output logic               ms_allowin,
    input  logic               es_to_ms_valid,
    input  logic               es_mem_req,
    input  logic [LD_OP_W-1:0] es_load_op,
    input  logic               es_mem_to_reg,
    input  logic               es_reg_we,
    input  logic [RA_W-1:0]    es_dest,
    input  logic [XLEN-1:0]    es_alu_result,
    input  logic [XLEN-1:0]    es_pc,
    input  logic [1:0]         es_div_op,
    input  logic [XLEN-1:0]    div_result,
    input  logic [XLEN-1:0]    mod_result,
    input  logic               data_sram_data_ok,
    input  logic [XLEN-1:0]    data_sram_rdata,
    output logic               ms_to_ws_valid,
    output logic               ms_reg_we,
    output logic [RA_W-1:0]    ms_dest,
    output logic [XLEN-1:0]    ms_final_result,
    output logic [XLEN-1:0]    ms_pc,
    output logic               ms_ale,
    output logic               ms_fw_we,
    output logic [RA_W-1:0]    ms_fw_dest,
    output logic               ms_fw_busy
);

    localparam int OFF_W = off_w(XLEN);

    ms_state_e          state_q, state_d;
    logic               reg_we_q, reg_we_d;
    logic               mem_to_reg_q, mem_to_reg_d;
    logic [RA_W-1:0]    dest_q, dest_d;
    logic [XLEN-1:0]    alu_result_q, alu_result_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [LD_OP_W-1:0] load_op_q, load_op_d;
    logic [1:0]         div_op_q, div_op_d;
    logic [XLEN-1:0]    rdata_buf_q, rdata_buf_d;

    logic               ms_valid;
    logic               accept;
    logic [XLEN-1:0]    load_result;
    logic               load_ale;

    assign ms_valid       = (state_q == MS_WAIT) || (state_q == MS_READY);
    assign ms_to_ws_valid = (state_q == MS_READY);
    assign ms_allowin     = (state_q == MS_EMPTY) || ((state_q == MS_READY) && ws_allowin);
    assign accept         = es_to_ms_valid && ms_allowin && !flush;

    always_comb begin
        state_d      = state_q;
        reg_we_d     = reg_we_q;
        mem_to_reg_d = mem_to_reg_q;
        dest_d       = dest_q;
        alu_result_d = alu_result_q;
        pc_d         = pc_q;
        load_op_d    = load_op_q;
        div_op_d     = div_op_q;
        rdata_buf_d  = rdata_buf_q;

        case (state_q)
            MS_EMPTY: begin
                if (accept) state_d = es_mem_req ? MS_WAIT : MS_READY;
            end
            MS_WAIT: begin
                // A flush with the response still outstanding must swallow it later.
                if (flush) begin
                    state_d = data_sram_data_ok ? MS_EMPTY : MS_DRAIN;
                end else if (data_sram_data_ok) begin
                    state_d     = MS_READY;
                    rdata_buf_d = data_sram_rdata;
                end
            end
            MS_READY: begin
                if (flush) begin
                    state_d = MS_EMPTY;
                end else if (ws_allowin) begin
                    if (accept) state_d = es_mem_req ? MS_WAIT : MS_READY;
                    else        state_d = MS_EMPTY;
                end
            end
            MS_DRAIN: begin
                if (data_sram_data_ok) state_d = MS_EMPTY;
            end
            default: state_d = MS_EMPTY;
        endcase

        if (accept) begin
            reg_we_d     = es_reg_we;
            mem_to_reg_d = es_mem_to_reg;
            dest_d       = es_dest;
            alu_result_d = es_alu_result;
            pc_d         = es_pc;
            load_op_d    = es_load_op;
            div_op_d     = es_div_op;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= MS_EMPTY;
            reg_we_q     <= 1'b0;
            mem_to_reg_q <= 1'b0;
            dest_q       <= '0;
            alu_result_q <= '0;
            pc_q         <= '0;
            load_op_q    <= '0;
            div_op_q     <= '0;
            rdata_buf_q  <= '0;
        end else begin
            state_q      <= state_d;
            reg_we_q     <= reg_we_d;
            mem_to_reg_q <= mem_to_reg_d;
            dest_q       <= dest_d;
            alu_result_q <= alu_result_d;
            pc_q         <= pc_d;
            load_op_q    <= load_op_d;
            div_op_q     <= div_op_d;
            rdata_buf_q  <= rdata_buf_d;
        end
    end

    load_align #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_load_align (
        .rdata   (rdata_buf_q),
        .offset  (alu_result_q[OFF_W-1:0]),
        .load_op (load_op_q),
        .result  (load_result),
        .ale     (load_ale)
    );

    always_comb begin
        if (mem_to_reg_q)     ms_final_result = load_result;
        else if (div_op_q[0]) ms_final_result = div_result;
        else if (div_op_q[1]) ms_final_result = mod_result;
        else                  ms_final_result = alu_result_q;
    end

    assign ms_reg_we  = reg_we_q;
    assign ms_dest    = dest_q;
    assign ms_pc      = pc_q;
    assign ms_ale     = mem_to_reg_q && load_ale;
    assign ms_fw_we   = reg_we_q && ms_valid;
    assign ms_fw_dest = dest_q;
    assign ms_fw_busy = (state_q == MS_WAIT) && mem_to_reg_q;

endmodule

// File: tb/tb_mem_resp_stage.sv
// tb/tb_mem_resp_stage.sv - self-checking bench for mem_resp_stage at XLEN 32 and 64
module tb_mem_resp_stage;

    logic        clk, reset, flush, ws_allowin;
    logic        es_to_ms_valid, es_mem_req, es_mem_to_reg, es_reg_we;
    logic [6:0]  es_load_op;
    logic [4:0]  es_dest;
    logic [63:0] es_alu_result, es_pc, div_result, mod_result, rdata;
    logic [1:0]  es_div_op;
    logic        data_ok;
    int          es_op;

    logic        a_allowin, a_to_ws, a_we, a_ale, a_fw_we, a_busy;
    logic [4:0]  a_dest, a_fw_dest;
    logic [31:0] a_res, a_pc;
    logic        b_allowin, b_to_ws, b_we, b_ale, b_fw_we, b_busy;
    logic [4:0]  b_dest, b_fw_dest;
    logic [63:0] b_res, b_pc;

    mem_resp_stage #(.XLEN(32), .RA_W(5)) u_dut32 (
        .clk(clk), .reset(reset), .flush(flush), .ws_allowin(ws_allowin), .ms_allowin(a_allowin),
        .es_to_ms_valid(es_to_ms_valid), .es_mem_req(es_mem_req), .es_load_op(es_load_op),
        .es_mem_to_reg(es_mem_to_reg), .es_reg_we(es_reg_we), .es_dest(es_dest),
        .es_alu_result(es_alu_result[31:0]), .es_pc(es_pc[31:0]), .es_div_op(es_div_op),
        .div_result(div_result[31:0]), .mod_result(mod_result[31:0]),
        .data_sram_data_ok(data_ok), .data_sram_rdata(rdata[31:0]),
        .ms_to_ws_valid(a_to_ws), .ms_reg_we(a_we), .ms_dest(a_dest), .ms_final_result(a_res),
        .ms_pc(a_pc), .ms_ale(a_ale), .ms_fw_we(a_fw_we), .ms_fw_dest(a_fw_dest), .ms_fw_busy(a_busy)
    );

    mem_resp_stage #(.XLEN(64), .RA_W(5)) u_dut64 (
        .clk(clk), .reset(reset), .flush(flush), .ws_allowin(ws_allowin), .ms_allowin(b_allowin),
        .es_to_ms_valid(es_to_ms_valid), .es_mem_req(es_mem_req), .es_load_op(es_load_op),
        .es_mem_to_reg(es_mem_to_reg), .es_reg_we(es_reg_we), .es_dest(es_dest),
        .es_alu_result(es_alu_result), .es_pc(es_pc), .es_div_op(es_div_op),
        .div_result(div_result), .mod_result(mod_result),
        .data_sram_data_ok(data_ok), .data_sram_rdata(rdata),
        .ms_to_ws_valid(b_to_ws), .ms_reg_we(b_we), .ms_dest(b_dest), .ms_final_result(b_res),
        .ms_pc(b_pc), .ms_ale(b_ale), .ms_fw_we(b_fw_we), .ms_fw_dest(b_fw_dest), .ms_fw_busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sext(input logic [63:0] x, input int n);
        logic [63:0] m;
        logic [63:0] r;
        m = (64'd1 << n) - 64'd1;
        r = x & m;
        if (r[n-1]) r = r | ~m;
        return r;
    endfunction

    function automatic logic [63:0] xmask(input int xlen);
        return (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic bit misal(input int op, input logic [63:0] addr);
        case (op)
            1, 4:    return addr[0];
            2, 5:    return addr[1:0] != 2'b00;
            6:       return addr[2:0] != 3'b000;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] ref_load(input int xlen, input logic [63:0] rd,
                                             input logic [63:0] addr, input int op);
        logic [63:0] v;
        logic [63:0] r;
        int off;
        rd  = rd & xmask(xlen);
        if (misal(op, addr)) return 64'd0;
        off = int'(addr % 64'(xlen / 8));
        v   = rd >> (8 * off);
        case (op)
            0: r = sext(v, 8);
            1: r = sext(v, 16);
            2: r = sext(v, 32);
            3: r = v & 64'hFF;
            4: r = v & 64'hFFFF;
            5: r = (xlen == 64) ? (v & 64'hFFFF_FFFF) : 64'd0;
            6: r = (xlen == 64) ? rd : 64'd0;
            default: r = 64'd0;
        endcase
        return r & xmask(xlen);
    endfunction

    // Transaction-level model: one slot that may be waiting for data, holding it, or draining.
    bit          m_valid, m_have, m_drain, m_m2r, m_we;
    int          m_op;
    logic [63:0] m_addr, m_pc, m_rdata;
    logic [4:0]  m_dest;
    logic [1:0]  m_div;

    function automatic logic [63:0] model_result(input int xlen);
        logic [63:0] r;
        if (m_m2r)         r = ref_load(xlen, m_rdata, m_addr, m_op);
        else if (m_div[0]) r = div_result;
        else if (m_div[1]) r = mod_result;
        else               r = m_addr;
        return r & xmask(xlen);
    endfunction

    task automatic cycle();
        bit exp_to, exp_allow, exp_busy, skip32;
        #2;
        exp_to    = m_valid && m_have;
        exp_allow = !m_drain && (!m_valid || (m_have && ws_allowin));
        exp_busy  = m_valid && !m_have && m_m2r;
        chk("to_ws32", a_to_ws, exp_to);
        chk("to_ws64", b_to_ws, exp_to);
        chk("allowin32", a_allowin, exp_allow);
        chk("allowin64", b_allowin, exp_allow);
        chk("busy32", a_busy, exp_busy);
        chk("busy64", b_busy, exp_busy);
        chk("fw_we32", a_fw_we, m_valid && m_we);
        chk("fw_we64", b_fw_we, m_valid && m_we);
        if (m_valid) begin
            chk("fw_dest32", a_fw_dest, m_dest);
            chk("fw_dest64", b_fw_dest, m_dest);
        end
        if (exp_to) begin
            skip32 = m_m2r && (m_op == 6);
            chk("result64", b_res, model_result(64));
            chk("ale64", b_ale, m_m2r && misal(m_op, m_addr));
            if (!skip32) begin
                chk("result32", a_res, model_result(32));
                chk("ale32", a_ale, m_m2r && misal(m_op, m_addr));
            end
            chk("dest64", b_dest, m_dest);
            chk("pc64", b_pc, m_pc);
            chk("pc32", a_pc, m_pc[31:0]);
            chk("we32", a_we, m_we);
        end
        if (m_drain) begin
            if (data_ok) m_drain = 0;
        end else if (flush) begin
            if (m_valid && !m_have && !data_ok) m_drain = 1;
            m_valid = 0;
        end else begin
            if (m_valid && !m_have && data_ok) begin
                m_have  = 1;
                m_rdata = rdata;
            end else if (m_valid && m_have && ws_allowin) begin
                m_valid = 0;
            end
            if (es_to_ms_valid && exp_allow) begin
                m_valid = 1;
                m_have  = !es_mem_req;
                m_m2r   = es_mem_to_reg;
                m_we    = es_reg_we;
                m_op    = es_op;
                m_addr  = es_alu_result;
                m_pc    = es_pc;
                m_dest  = es_dest;
                m_div   = es_div_op;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; ws_allowin = 1; es_to_ms_valid = 0; es_mem_req = 0; es_mem_to_reg = 0;
        es_reg_we = 0; es_load_op = 0; es_dest = 0; es_alu_result = 0; es_pc = 0; es_div_op = 0;
        div_result = 0; mod_result = 0; data_ok = 0; rdata = 0; es_op = -1;
    endtask

    task automatic drive(input int op, input logic [63:0] addr, input bit req, input logic [1:0] div);
        es_to_ms_valid = 1;
        es_op          = op;
        es_mem_to_reg  = (op >= 0);
        es_load_op     = (op >= 0) ? 7'(1 << op) : 7'd0;
        es_mem_req     = req;
        es_alu_result  = addr;
        es_div_op      = div;
        es_reg_we      = 1'($urandom);
        es_dest        = 5'($urandom);
        es_pc          = {$urandom, $urandom};
    endtask

    typedef struct {
        int          op;
        logic [63:0] addr;
        logic [63:0] rd;
        logic [1:0]  div;
        logic [63:0] divr;
        logic [63:0] modr;
        logic [63:0] exp32;
        logic [63:0] exp64;
        bit          ale;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        vecs.push_back('{0, 64'h3, 64'h80FF_1234, 2'b00, 0, 0, 64'hFFFF_FF80, 64'hFFFF_FFFF_FFFF_FF80, 0});
        vecs.push_back('{3, 64'h2, 64'h80FF_1234, 2'b00, 0, 0, 64'hFF, 64'hFF, 0});
        vecs.push_back('{1, 64'h2, 64'h80FF_1234, 2'b00, 0, 0, 64'hFFFF_80FF, 64'hFFFF_FFFF_FFFF_80FF, 0});
        vecs.push_back('{4, 64'h2, 64'hBEEF_0000, 2'b00, 0, 0, 64'hBEEF, 64'hBEEF, 0});
        vecs.push_back('{2, 64'h4, 64'h8000_0001_1234_5678, 2'b00, 0, 0, 64'h1234_5678, 64'hFFFF_FFFF_8000_0001, 0});
        vecs.push_back('{5, 64'h4, 64'h8000_0001_1234_5678, 2'b00, 0, 0, 64'h0, 64'h8000_0001, 0});
        vecs.push_back('{6, 64'h0, 64'h8000_0001_1234_5678, 2'b00, 0, 0, 64'h0, 64'h8000_0001_1234_5678, 0});
        vecs.push_back('{0, 64'h7, 64'h7F00_0000_0000_0000, 2'b00, 0, 0, 64'h0, 64'h7F, 0});
        vecs.push_back('{2, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 0, 0, 64'h0, 64'h0, 1});
        vecs.push_back('{1, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 0, 0, 64'h0, 64'h0, 1});
        vecs.push_back('{-1, 64'h40, 0, 2'b01, 64'h7, 64'h9, 64'h7, 64'h7, 0});
        vecs.push_back('{-1, 64'h40, 0, 2'b10, 64'h7, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 0});
        vecs.push_back('{-1, 64'h1234_5678_9ABC_DEF0, 0, 2'b00, 64'h7, 64'h9, 64'h9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 0});
        vecs.push_back('{-1, 64'h40, 0, 2'b11, 64'h3, 64'h9, 64'h3, 64'h3, 0});

        idle();
        m_valid = 0; m_have = 0; m_drain = 0; m_m2r = 0; m_we = 0; m_op = -1;
        m_addr = 0; m_pc = 0; m_rdata = 0; m_dest = 0; m_div = 0;
        reset = 1;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        div_result = 64'hDEAD_BEEF_DEAD_BEEF;
        #1;
        chk("rst_allowin", a_allowin, 1);
        chk("rst_to_ws", a_to_ws, 0);
        chk("rst_result32", a_res, 0);
        chk("rst_result64", b_res, 0);
        chk("rst_pc", b_pc, 0);
        chk("rst_dest", b_dest, 0);
        chk("rst_ale", b_ale, 0);
        chk("rst_we", a_we, 0);
        chk("rst_busy", b_busy, 0);
        chk("rst_fw_we", b_fw_we, 0);
        div_result = 0;

        foreach (vecs[i]) begin
            bit req;
            req = (vecs[i].op >= 0) && !vecs[i].ale;
            drive(vecs[i].op, vecs[i].addr, req, vecs[i].div);
            div_result = vecs[i].divr;
            mod_result = vecs[i].modr;
            cycle();
            es_to_ms_valid = 0;
            if (req) begin
                data_ok = 1; rdata = vecs[i].rd;
                cycle();
                data_ok = 0; rdata = 0;
            end
            ws_allowin = 0;
            #1;
            chk("vec_valid", b_to_ws, 1);
            chk("vec_result32", a_res, vecs[i].exp32);
            chk("vec_result64", b_res, vecs[i].exp64);
            chk("vec_ale32", a_ale, vecs[i].ale);
            chk("vec_ale64", b_ale, vecs[i].ale);
            cycle();
            ws_allowin = 1;
            cycle();
        end

        // lb with three-cycle data latency
        idle();
        drive(0, 64'h1003, 1, 2'b00);
        cycle();
        es_to_ms_valid = 0;
        for (int k = 0; k < 3; k++) begin
            data_ok = (k == 2);
            rdata   = (k == 2) ? 64'h80FF_1234 : 64'h0;
            #1;
            chk("A_busy", a_busy, 1);
            cycle();
        end
        data_ok = 0; rdata = 0;
        #1;
        chk("A_valid", a_to_ws, 1);
        chk("A_result32", a_res, 64'hFFFF_FF80);
        cycle();

        // lhu held by WB stall while EX keeps offering
        idle();
        drive(4, 64'h2002, 1, 2'b00);
        cycle();
        es_to_ms_valid = 0;
        data_ok = 1; rdata = 64'hBEEF_0000;
        cycle();
        data_ok = 0; rdata = 0;
        ws_allowin = 0;
        drive(-1, 64'h99, 0, 2'b00);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("B_allowin", a_allowin, 0);
            chk("B_hold_result", a_res, 64'hBEEF);
            chk("B_hold_valid", a_to_ws, 1);
            cycle();
        end
        es_to_ms_valid = 0;
        ws_allowin = 1;
        #1;
        chk("B_retire_valid", a_to_ws, 1);
        cycle();
        #1;
        chk("B_after_retire", a_to_ws, 0);

        // ALU op retires while a load enters with no bubble
        idle();
        drive(-1, 64'h5, 0, 2'b00);
        cycle();
        drive(2, 64'h8, 1, 2'b00);
        #1;
        chk("C_allowin", a_allowin, 1);
        chk("C_alu_result", a_res, 64'h5);
        cycle();
        es_to_ms_valid = 0;
        #1;
        chk("C_load_busy", a_busy, 1);
        chk("C_load_not_ready", a_to_ws, 0);
        data_ok = 1; rdata = 64'h1122_3344;
        cycle();
        data_ok = 0; rdata = 0;
        #1;
        chk("C_load_result", b_res, 64'h1122_3344);
        cycle();

        // flush while waiting, response arrives two cycles later
        idle();
        drive(0, 64'h10, 1, 2'b00);
        cycle();
        es_to_ms_valid = 0;
        flush = 1;
        cycle();
        flush = 0;
        for (int k = 0; k < 2; k++) begin
            data_ok = (k == 1); rdata = 64'hFF;
            #1;
            chk("D_allowin", a_allowin, 0);
            chk("D_to_ws", a_to_ws, 0);
            chk("D_busy", a_busy, 0);
            cycle();
        end
        data_ok = 0;
        #1;
        chk("D_empty_allowin", b_allowin, 1);
        chk("D_empty_to_ws", b_to_ws, 0);

        // misaligned lw skips the memory wait
        idle();
        drive(2, 64'h2, 0, 2'b00);
        cycle();
        es_to_ms_valid = 0;
        #1;
        chk("E_valid", a_to_ws, 1);
        chk("E_ale", a_ale, 1);
        chk("E_result", a_res, 0);
        cycle();

        idle();
        for (int n = 0; n < 3000; n++) begin
            flush      = ($urandom % 12) == 0;
            ws_allowin = ($urandom % 4) != 0;
            if (($urandom % 3) == 0) begin
                int op;
                logic [63:0] addr;
                op   = int'($urandom % 7);
                addr = {$urandom, $urandom};
                drive(op, addr, !misal(op, addr), 2'b00);
            end else begin
                drive(-1, {$urandom, $urandom}, 0, 2'($urandom));
            end
            es_to_ms_valid = 1'($urandom);
            div_result = {$urandom, $urandom};
            mod_result = {$urandom, $urandom};
            data_ok    = ((m_valid && !m_have) || m_drain) && (($urandom % 3) == 0);
            rdata      = {$urandom, $urandom};
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
